// File: rtl/io_ccff_chain_loader.sv
// rtl/io_ccff_chain_loader.sv - I/O tile column configuration chain loader (optional readback: CCFF_READBACK_VERIFY_EN)
module io_ccff_chain_loader #(
    parameter int CHAIN_LEN = 4,
    parameter int WORD_W    = 8,
    parameter int ISO_CYC   = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int REM_W = $clog2(WORD_W + 1);
    localparam int ISO_W = $clog2(ISO_CYC + 1);

    localparam logic [CNT_W-1:0] CHAIN_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [ISO_W-1:0] ISO_LAST   = ISO_W'(ISO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISOLATE = 3'd1,
        S_SHIFT   = 3'd2,
`ifdef CCFF_READBACK_VERIFY_EN
        S_VERIFY  = 3'd3,
`endif
        S_RELEASE = 3'd4
    } state_t;

    // CRC-8, polynomial 0x07, one bit per call, MSB-first
    function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic b);
        crc8_bit = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    state_t             state_q, state_n;
    logic [ISO_W-1:0]   iso_cnt_q, iso_cnt_n;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
    logic [CNT_W-1:0]   taken_q, taken_n;
    logic [WORD_W-1:0]  sreg_q, sreg_n;
    logic [REM_W-1:0]   rem_q, rem_n;
    logic [7:0]         crc_q, crc_n;
    logic               head_q, head_n;
    logic               shift_en_q, shift_en_n;
    logic               ready_q, ready_n;
    logic               isol_n_q, isol_n_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               accept;
    int                 left_bits;
    int                 used_bits;

`ifdef CCFF_READBACK_VERIFY_EN
    logic [7:0]         crc_rb_q, crc_rb_n;
    logic [CNT_W-1:0]   vcnt_q, vcnt_n;
    logic               error_q, error_n;
`endif

    // Next-state and next-output logic; bits held in the serialiser beyond the
    // one on the head are counted by rem, bits taken from words by taken.
    always_comb begin
        state_n    = state_q;
        iso_cnt_n  = iso_cnt_q;
        bit_cnt_n  = bit_cnt_q;
        taken_n    = taken_q;
        sreg_n     = sreg_q;
        rem_n      = rem_q;
        crc_n      = crc_q;
        head_n     = head_q;
        shift_en_n = 1'b0;
        isol_n_n   = isol_n_q;
        done_n     = 1'b0;
        accept     = cfg_valid & ready_q;
        left_bits  = CHAIN_LEN - int'(taken_q);
        used_bits  = (left_bits < WORD_W) ? left_bits : WORD_W;
`ifdef CCFF_READBACK_VERIFY_EN
        crc_rb_n   = crc_rb_q;
        vcnt_n     = vcnt_q;
        error_n    = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_ISOLATE;
                    isol_n_n  = 1'b0;
                    iso_cnt_n = '0;
                    bit_cnt_n = '0;
                    taken_n   = '0;
                    rem_n     = '0;
                    crc_n     = 8'h00;
                    head_n    = 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
                    crc_rb_n  = 8'h00;
                    error_n   = 1'b0;
`endif
                end
            end
            S_ISOLATE: begin
                if (iso_cnt_q == ISO_LAST) begin
                    state_n   = S_SHIFT;
                    iso_cnt_n = '0;
                end else begin
                    iso_cnt_n = iso_cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (shift_en_q) begin
                    crc_n = crc8_bit(crc_q, head_q);
                    if (bit_cnt_q != CHAIN_FULL) begin
                        bit_cnt_n = bit_cnt_q + 1'b1;
                    end
                end
                if (shift_en_q && (bit_cnt_q == CHAIN_LAST)) begin
                    head_n    = 1'b0;
                    iso_cnt_n = '0;
`ifdef CCFF_READBACK_VERIFY_EN
                    state_n    = S_VERIFY;
                    shift_en_n = 1'b1;
                    vcnt_n     = '0;
`else
                    state_n    = S_RELEASE;
`endif
                end else if (accept) begin
                    head_n     = cfg_data[WORD_W-1];
                    sreg_n     = cfg_data << 1;
                    rem_n      = REM_W'(used_bits - 1);
                    taken_n    = taken_q + CNT_W'(used_bits);
                    shift_en_n = 1'b1;
                end else if (rem_q != '0) begin
                    head_n     = sreg_q[WORD_W-1];
                    sreg_n     = sreg_q << 1;
                    rem_n      = rem_q - 1'b1;
                    shift_en_n = 1'b1;
                end
            end
`ifdef CCFF_READBACK_VERIFY_EN
            S_VERIFY: begin
                crc_rb_n   = crc8_bit(crc_rb_q, ccff_tail);
                shift_en_n = 1'b1;
                if (vcnt_q == CHAIN_LAST) begin
                    shift_en_n = 1'b0;
                    state_n    = S_RELEASE;
                    iso_cnt_n  = '0;
                    if (crc_rb_n != crc_q) begin
                        error_n = 1'b1;
                    end
                end else begin
                    vcnt_n = vcnt_q + 1'b1;
                end
            end
`endif
            S_RELEASE: begin
                if (iso_cnt_q == ISO_LAST) begin
                    state_n   = S_IDLE;
                    iso_cnt_n = '0;
`ifdef CCFF_READBACK_VERIFY_EN
                    if (!error_q) begin
                        isol_n_n = 1'b1;
                        done_n   = 1'b1;
                    end
`else
                    isol_n_n = 1'b1;
                    done_n   = 1'b1;
`endif
                end else begin
                    iso_cnt_n = iso_cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        ready_n = (state_n == S_SHIFT) && (rem_n == '0) && (taken_n != CHAIN_FULL);
        busy_n  = (state_n != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q    <= S_IDLE;
            iso_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            taken_q    <= '0;
            sreg_q     <= '0;
            rem_q      <= '0;
            crc_q      <= 8'h00;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            ready_q    <= 1'b0;
            isol_n_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            iso_cnt_q  <= iso_cnt_n;
            bit_cnt_q  <= bit_cnt_n;
            taken_q    <= taken_n;
            sreg_q     <= sreg_n;
            rem_q      <= rem_n;
            crc_q      <= crc_n;
            head_q     <= head_n;
            shift_en_q <= shift_en_n;
            ready_q    <= ready_n;
            isol_n_q   <= isol_n_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

`ifdef CCFF_READBACK_VERIFY_EN
    // Readback CRC, verify counter and sticky error flag
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            crc_rb_q <= 8'h00;
            vcnt_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            crc_rb_q <= crc_rb_n;
            vcnt_q   <= vcnt_n;
            error_q  <= error_n;
        end
    end

    // During recirculation the tail is looped straight back to the head so
    // the chain length seen by the data is unchanged.
    assign ccff_head = (state_q == S_VERIFY) ? ccff_tail : head_q;
    assign error     = error_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign error       = 1'b0;
`endif

    assign cfg_ready     = ready_q;
    assign ccff_shift_en = shift_en_q;
    assign isol_n        = isol_n_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
